// File: rtl/quad_encoder_pkg.sv
// Shared types and decode helpers for the quadrature encoder bank.
// Phase encoding is {A,B}; forward rotation is 00->10->11->01->00.
package quad_encoder_pkg;

  localparam int MODE_HALF = 0;
  localparam int MODE_X4   = 1;

  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic inc;
    logic dec;
    logic err;
  } dec_t;

  function automatic phase_t fwd_of(phase_t p);
    phase_t r;
    r = 2'b00;
    unique case (1'b1)
      (p == 2'b00): r = 2'b10;
      (p == 2'b10): r = 2'b11;
      (p == 2'b11): r = 2'b01;
      (p == 2'b01): r = 2'b00;
      default:      r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic dec_t decode(
    phase_t p,
    phase_t c,
    int     mode
  );
    dec_t r;
    r = '0;
    if ((p ^ c) == 2'b11) begin
      r.err = 1'b1;
    end else if (p != c) begin
      if (mode == MODE_X4) begin
        r.inc = (c == fwd_of(p));
        r.dec = (p == fwd_of(c));
      end else begin
        // legacy decode only acts on one edge of each pin pair
        r.inc = (!p[1] && c[1] && !c[0]) ||
                (p[1] && !c[1] && c[0]);
        r.dec = (!p[0] && c[0] && !c[1]) ||
                (p[0] && !c[0] && c[1]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: synchroniser, optional glitch filter
// (QENC_GLITCH_FILTER_EN), direction decode and bounded counter.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int INITIAL_VAL   = 0,
  parameter int INCREMENT     = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int SATURATE      = 1,
  parameter int MODE          = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             error
);

  localparam int WW = $clog2(SYNC_STAGES + FILTER_CYCLES + 2);
`ifdef QENC_GLITCH_FILTER_EN
  localparam int WARM = SYNC_STAGES + 1 + FILTER_CYCLES;
`else
  localparam int WARM = SYNC_STAGES + 1;
`endif

  localparam logic [WIDTH:0] MAX1 = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MIN1 = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] INC1 = (WIDTH+1)'(INCREMENT);
  localparam logic [WIDTH-1:0] INIT = WIDTH'(INITIAL_VAL);

  logic [SYNC_STAGES-1:0] sa, sb;
  phase_t raw, cur, prev;
  logic [WW-1:0] warm;
  logic live;
  dec_t d;
  logic [WIDTH:0] v1, n_inc, n_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa <= '0;
      sb <= '0;
    end else begin
      sa <= {sa[SYNC_STAGES-2:0], a};
      sb <= {sb[SYNC_STAGES-2:0], b};
    end
  end

  assign raw = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};

`ifdef QENC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  phase_t filt;
  logic [CW-1:0] fcnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_CYCLES - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign cur = filt;
`else
  assign cur = raw;
`endif

  assign live = (warm == WW'(WARM));
  assign d    = decode(prev, cur, MODE);
  assign v1   = {1'b0, value};

  always_comb begin
    n_inc = v1 + INC1;
    if (n_inc > MAX1)
      n_inc = (SATURATE != 0) ? MAX1 : MIN1;
    n_dec = v1 - INC1;
    if (v1 < MIN1 + INC1)
      n_dec = (SATURATE != 0) ? MIN1 : MAX1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= INIT;
      step  <= 1'b0;
      dir   <= 1'b0;
      error <= 1'b0;
      prev  <= '0;
      warm  <= '0;
    end else begin
      prev  <= cur;
      step  <= 1'b0;
      error <= 1'b0;
      if (!live)
        warm <= warm + 1'b1;
      else
        error <= d.err;
      if (clear) begin
        value <= INIT;
      end else if (live && (d.inc || d.dec)) begin
        step  <= 1'b1;
        dir   <= d.inc;
        value <= d.inc ? n_inc[WIDTH-1:0]
                       : n_dec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of independent quadrature encoder channels; bus packing only.
// Optional glitch filter enabled by defining QENC_GLITCH_FILTER_EN.
module quad_encoder_bank
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int WIDTH         = 8,
  parameter int INITIAL_VAL   = 0,
  parameter int INCREMENT     = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int SATURATE      = 1,
  parameter int MODE          = MODE_HALF,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       error
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    quad_encoder_channel #(
      .WIDTH        (WIDTH),
      .INITIAL_VAL  (INITIAL_VAL),
      .INCREMENT    (INCREMENT),
      .MIN_VAL      (MIN_VAL),
      .MAX_VAL      (MAX_VAL),
      .SATURATE     (SATURATE),
      .MODE         (MODE),
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .a    (a[n]),
      .b    (b[n]),
      .clear(clear[n]),
      .value(value[n*WIDTH +: WIDTH]),
      .step (step[n]),
      .dir  (dir[n]),
      .error(error[n])
    );
  end

endmodule
